// File: rtl/tb_watchdog_monitor.sv
// Multi-channel watchdog: per-channel IDLE/ARMED/EXPIRED FSM with kick counter.
// Define TB_WATCHDOG_FINISH_EN to end simulation on the first expiry.
module tb_watchdog_monitor #(
  parameter int CHANNELS   = 4,
  parameter int LIMIT      = 8,
  parameter int EVENTWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic [CHANNELS-1:0]   Arm,
  input  logic [CHANNELS-1:0]   Kick,
  input  logic [CHANNELS-1:0]   Disarm,
  output logic [CHANNELS-1:0]   Armed,
  output logic [CHANNELS-1:0]   Expired,
  output logic                  AnyExpired,
  output logic [EVENTWIDTH-1:0] EventCount
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam int SW = EVENTWIDTH + 6;
  localparam logic [CW-1:0] LIM = CW'(LIMIT);
  localparam logic [EVENTWIDTH-1:0] EV_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXPIRED
  } state_t;

  state_t                state_q [CHANNELS];
  state_t                state_d [CHANNELS];
  logic [CW-1:0]         cnt_q   [CHANNELS];
  logic [CW-1:0]         cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]   hit;
  logic [EVENTWIDTH-1:0] event_q;
  logic [EVENTWIDTH-1:0] event_d;
  logic [SW-1:0]         event_sum;

  // Per-channel next state; hit marks an ARMED->EXPIRED step this cycle
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      hit[i]     = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (Arm[i] && !Disarm[i]) begin
            state_d[i] = ARMED;
            cnt_d[i]   = '0;
          end
        end
        ARMED: begin
          if (Disarm[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (Kick[i] || Arm[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CW'(1) == LIM) begin
            state_d[i] = EXPIRED;
            cnt_d[i]   = LIM;
            hit[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        EXPIRED: begin
          if (Disarm[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Saturating add of all expiries that land on the same edge
  always_comb begin
    event_sum = SW'(event_q);
    for (int i = 0; i < CHANNELS; i++) begin
      event_sum = event_sum + SW'(hit[i]);
    end
    if (event_sum > SW'(EV_MAX)) begin
      event_d = EV_MAX;
    end else begin
      event_d = event_sum[EVENTWIDTH-1:0];
    end
  end

  // State, counters and event total with synchronous reset
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      event_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      event_q <= event_d;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      Armed[i]   = (state_q[i] == ARMED);
      Expired[i] = (state_q[i] == EXPIRED);
    end
  end

  assign AnyExpired = |Expired;
  assign EventCount = event_q;

`ifndef SYNTHESIS
  // One message per expiring channel, reporting the updated total
  always_ff @(posedge clk) begin
    if (sync_rst_n && |hit) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit[i]) begin
          $display("watchdog: channel %0d expired, LIMIT=%0d, EventCount=%0d",
                   i, LIMIT, event_d);
        end
      end
`ifdef TB_WATCHDOG_FINISH_EN
      $finish;
`endif
    end
  end
`endif

endmodule

// File: doc/tb_watchdog_monitor.md
TB_WATCHDOG_MONITOR -- requirements
Module: tb_watchdog_monitor

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 4, number of independent watchdog channels (1..32).
REQ-002 The block SHALL take parameter LIMIT, default 8, cycles without a kick before a channel expires (>= 1).
REQ-003 The block SHALL take parameter EVENTWIDTH, default 8, width of the expiry event counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 sync_rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-006 Arm  input  CHANNELS  per-channel start request.
REQ-007 Kick  input  CHANNELS  per-channel restart of the cycle count.
REQ-008 Disarm  input  CHANNELS  per-channel stop and clear, including clearing an expiry.
REQ-009 Armed  output  CHANNELS  per-channel high while in ARMED.
REQ-010 Expired  output  CHANNELS  per-channel sticky expiry flag, high while in EXPIRED.
REQ-011 AnyExpired  output  1  OR of all Expired bits.
REQ-012 EventCount  output  EVENTWIDTH  total ARMED-to-EXPIRED transitions since reset.

Function
REQ-013 Each channel SHALL hold a 3-state FSM (IDLE, ARMED, EXPIRED) and a counter of width clog2(LIMIT+1).
REQ-014 IDLE: Arm high and Disarm low -> ARMED with counter 0; Kick alone is ignored.
REQ-015 ARMED: priority Disarm > (Kick or Arm) > count; Disarm -> IDLE, counter 0; Kick or Arm -> counter 0, stay ARMED.
REQ-016 ARMED, no Disarm/Kick/Arm: counter +1 per cycle; when the incremented value equals LIMIT the channel SHALL enter EXPIRED instead.
REQ-017 Latency: with Arm sampled at edge 0 and no further inputs, Expired SHALL rise immediately after edge LIMIT (LIMIT=1 -> after edge 1).
REQ-018 EXPIRED: Kick and Arm ignored; Disarm -> IDLE, counter 0; state otherwise held indefinitely.
REQ-019 Counter SHALL never exceed LIMIT; no wrap-around in any state.
REQ-020 Armed, Expired and AnyExpired SHALL be driven from registered state only, with no combinational path from inputs.
REQ-021 EventCount SHALL increment by the number of channels entering EXPIRED on the same edge, saturating at 2^EVENTWIDTH-1.
REQ-022 Each ARMED-to-EXPIRED transition SHALL print exactly one simulation message stating channel index, LIMIT and EventCount after update.
REQ-023 Channels SHALL be fully independent; inputs for channel i SHALL never affect channel j.

Reset
REQ-024 While sync_rst_n is low at a rising edge, all channels SHALL go to IDLE, counters to 0, Armed=0, Expired=0, AnyExpired=0, EventCount=0.
REQ-025 Reset SHALL override all inputs, including reset asserted mid-count or in EXPIRED; no message SHALL print on the reset edge.
REQ-026 Outputs SHALL be undefined only before the first reset edge.

Configuration
REQ-027 With macro TB_WATCHDOG_FINISH_EN defined, the first expiry message SHALL be followed by ending the simulation on that same edge.
REQ-028 Without TB_WATCHDOG_FINISH_EN, expiry SHALL only set flags, count and print; simulation continues.

Verification
REQ-029 CHANNELS=4, LIMIT=8: Arm[0] pulse at edge 0, no kicks -> Expired[0]=1 after edge 8, EventCount=1, Armed[0]=0.
REQ-030 Arm[1] at edge 0, Kick[1] at edges 5 and 10 -> Expired[1] rises after edge 18, not before.
REQ-031 Arm[2] at edge 0, Disarm[2] and Kick[2] together at edge 4 -> IDLE after edge 4, Expired[2] stays 0 for 20 cycles.
REQ-032 Arm[0] and Arm[3] on the same edge, no kicks -> both expire on the same edge, EventCount steps 0->2, two messages.
REQ-033 Channel in EXPIRED, Kick applied then Disarm -> Expired held through Kick, clears after the Disarm edge; re-Arm expires again after 8 cycles.
REQ-034 sync_rst_n low for one edge at counter=5 and after an expiry -> all outputs 0, EventCount=0; LIMIT=1 build expires one edge after Arm.
